// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common data bus scheduler for the out-of-order core.
// Every result producer has a one-entry holding buffer with a valid/ready
// handshake. A round-robin scheduler picks one buffered result per cycle and
// broadcasts it on registered CDB outputs. A mispredict flush empties all
// buffers. A saturating counter records cycles with two or more waiting results.
module cdb_arbiter #(
    parameter int          NUM_REQ     = 2,    // 2..4; 0 = ALU, 1 = memory unit
    parameter int          ROB_ID_W    = 5,
    parameter int          PHY_W       = 6,
    parameter int          DATA_W      = 32,
    // Reset value of contention_cnt. Keep at 0 in normal use. A value near
    // the top lets saturation be reached without 2^32 contended cycles.
    parameter logic [31:0] CNT_RST_VAL = 32'h0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ROB_ID_W-1:0]   req_rob_id,
    input  logic [NUM_REQ*PHY_W-1:0]      req_phy_dst,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic                          cdb_valid,
    output logic [ROB_ID_W-1:0]           cdb_rob_id,
    output logic [PHY_W-1:0]              cdb_phy_dst,
    output logic [DATA_W-1:0]             cdb_data,
    output logic [$clog2(NUM_REQ)-1:0]    cdb_src,
    output logic [31:0]                   contention_cnt
);

    localparam int SRC_W = $clog2(NUM_REQ);

    // Holding buffers, one entry per requester
    logic [NUM_REQ-1:0]  buf_valid;
    logic [ROB_ID_W-1:0] buf_rob_id  [NUM_REQ];
    logic [PHY_W-1:0]    buf_phy_dst [NUM_REQ];
    logic [DATA_W-1:0]   buf_data    [NUM_REQ];

    // Round-robin pointer: highest-priority requester for the next grant
    logic [SRC_W-1:0]    rr_ptr;
    logic [SRC_W-1:0]    rr_next;

    // Arbitration results
    logic                grant_found;
    logic [SRC_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0]  grant_vec;

    // Number of occupied buffers, for contention accounting
    logic [2:0]          n_valid;
    logic                contended;

    // Round-robin search starting at rr_ptr; first valid buffer wins
    always_comb begin
        int               pos;
        logic [SRC_W-1:0] idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_vec   = '0;
        pos         = 0;
        idx         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = (int'(rr_ptr) + k) % NUM_REQ;
            idx = SRC_W'(pos);
            if (!grant_found && buf_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
        if (grant_found) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    // Pointer moves to the requester just after the one granted (wraps)
    always_comb begin
        rr_next = rr_ptr;
        if (grant_found) begin
            if (int'(grant_idx) == NUM_REQ - 1) begin
                rr_next = '0;
            end else begin
                rr_next = grant_idx + SRC_W'(1);
            end
        end
    end

    // Buffer can take a new entry when empty or being drained this cycle
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = !flush && (!buf_valid[i] || grant_vec[i]);
        end
    end

    // Count occupied buffers to detect contention
    always_comb begin
        n_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            n_valid = n_valid + {2'b00, buf_valid[i]};
        end
        contended = (n_valid >= 3'd2);
    end

    // Holding buffers: accept takes precedence over drain on the same entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_valid <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                buf_rob_id[i]  <= '0;
                buf_phy_dst[i] <= '0;
                buf_data[i]    <= '0;
            end
        end else if (flush) begin
            buf_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    buf_valid[i]   <= 1'b1;
                    buf_rob_id[i]  <= req_rob_id[i*ROB_ID_W +: ROB_ID_W];
                    buf_phy_dst[i] <= req_phy_dst[i*PHY_W +: PHY_W];
                    buf_data[i]    <= req_data[i*DATA_W +: DATA_W];
                end else if (grant_vec[i]) begin
                    buf_valid[i]   <= 1'b0;
                end
            end
        end
    end

    // Registered CDB broadcast; payload fields hold when nothing is granted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cdb_valid   <= 1'b0;
            cdb_rob_id  <= '0;
            cdb_phy_dst <= '0;
            cdb_data    <= '0;
            cdb_src     <= '0;
        end else if (flush) begin
            cdb_valid   <= 1'b0;
        end else begin
            cdb_valid <= grant_found;
            if (grant_found) begin
                cdb_rob_id  <= buf_rob_id[grant_idx];
                cdb_phy_dst <= buf_phy_dst[grant_idx];
                cdb_data    <= buf_data[grant_idx];
                cdb_src     <= grant_idx;
            end
        end
    end

    // Round-robin pointer; a flush leaves it where it was
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (!flush) begin
            rr_ptr <= rr_next;
        end
    end

    // Saturating contention counter; flush cycles are not counted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            contention_cnt <= CNT_RST_VAL;
        end else if (!flush && contended && (contention_cnt != 32'hFFFF_FFFF)) begin
            contention_cnt <= contention_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with two requesters (ALU = 0, memory = 1).
// A second instance with a preloaded contention counter shares all inputs
// and is used for the saturation checks.
module tb_cdb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_rob_id;
    logic [11:0] req_phy_dst;
    logic [63:0] req_data;
    logic        cdb_valid;
    logic [4:0]  cdb_rob_id;
    logic [5:0]  cdb_phy_dst;
    logic [31:0] cdb_data;
    logic [0:0]  cdb_src;
    logic [31:0] contention_cnt;

    logic [1:0]  s_req_ready;
    logic        s_cdb_valid;
    logic [4:0]  s_cdb_rob_id;
    logic [5:0]  s_cdb_phy_dst;
    logic [31:0] s_cdb_data;
    logic [0:0]  s_cdb_src;
    logic [31:0] s_contention_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    int         alu_tag;
    int         mem_tag;
    logic [1:0] vld;

    cdb_arbiter #(.NUM_REQ(2), .ROB_ID_W(5), .PHY_W(6), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rob_id(req_rob_id), .req_phy_dst(req_phy_dst), .req_data(req_data),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_phy_dst(cdb_phy_dst),
        .cdb_data(cdb_data), .cdb_src(cdb_src), .contention_cnt(contention_cnt)
    );

    cdb_arbiter #(.NUM_REQ(2), .ROB_ID_W(5), .PHY_W(6), .DATA_W(32),
                  .CNT_RST_VAL(32'hFFFF_FFFD)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(s_req_ready),
        .req_rob_id(req_rob_id), .req_phy_dst(req_phy_dst), .req_data(req_data),
        .cdb_valid(s_cdb_valid), .cdb_rob_id(s_cdb_rob_id), .cdb_phy_dst(s_cdb_phy_dst),
        .cdb_data(s_cdb_data), .cdb_src(s_cdb_src), .contention_cnt(s_contention_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive request pins from the current tags
    task automatic apply();
        req_valid   = vld;
        req_rob_id  = {5'(mem_tag), 5'(alu_tag)};
        req_phy_dst = {6'(mem_tag + 2), 6'(alu_tag + 1)};
        req_data    = {32'hB000_0000 + 32'(mem_tag), 32'hA000_0000 + 32'(alu_tag)};
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Clock edge with producer behaviour: a tag advances once it is accepted
    task automatic tick_hs();
        logic [1:0] acc;
        acc = rst_n ? (req_valid & req_ready) : 2'b00;
        @(posedge clk);
        #1;
        if (acc[0]) alu_tag++;
        if (acc[1]) mem_tag++;
        apply();
        #1;
    endtask

    initial begin
        logic [31:0] exp_tag;
        logic [31:0] exp_src;
        logic [31:0] exp_data;

        rst_n = 1'b0; flush = 1'b0; vld = 2'b00;
        alu_tag = 0; mem_tag = 0;
        apply();
        tick();
        tick();
        rst_n = 1'b1;
        #1;

        // Reset state
        chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("rst_cdb_rob",   32'(cdb_rob_id), 32'd0);
        chk("rst_cdb_data",  cdb_data, 32'd0);
        chk("rst_cdb_src",   32'(cdb_src), 32'd0);
        chk("rst_cnt",       contention_cnt, 32'd0);
        chk("rst_ready",     32'(req_ready), 32'd3);

        // Single requester
        req_valid = 2'b01;
        req_rob_id[4:0] = 5'd3;
        req_phy_dst[5:0] = 6'd10;
        req_data[31:0] = 32'hDEAD_BEEF;
        #1;
        chk("single_ready_pre", 32'(req_ready[0]), 32'd1);
        tick();
        req_valid = 2'b00;
        #1;
        chk("single_not_yet", 32'(cdb_valid), 32'd0);
        chk("single_ready_mid", 32'(req_ready[0]), 32'd1);
        tick();
        chk("single_valid", 32'(cdb_valid), 32'd1);
        chk("single_rob",   32'(cdb_rob_id), 32'd3);
        chk("single_phy",   32'(cdb_phy_dst), 32'd10);
        chk("single_data",  cdb_data, 32'hDEAD_BEEF);
        chk("single_src",   32'(cdb_src), 32'd0);
        chk("single_ready_post", 32'(req_ready[0]), 32'd1);
        tick();
        chk("single_pulse", 32'(cdb_valid), 32'd0);
        chk("single_hold",  cdb_data, 32'hDEAD_BEEF);

        // Contention / backpressure: both producers stream, edges k = 1..10
        rst_n = 1'b0; vld = 2'b00; apply();
        tick_hs();
        rst_n = 1'b1;
        alu_tag = 0; mem_tag = 16; vld = 2'b11;
        apply();
        for (int k = 1; k <= 10; k++) begin
            tick_hs();
            chk($sformatf("cont_ready_%0d", k), 32'(req_ready),
                (k % 2 == 1) ? 32'd1 : 32'd2);
            if (k == 1) begin
                chk("cont_first_idle", 32'(cdb_valid), 32'd0);
                chk("cont_cnt_1", contention_cnt, 32'd0);
            end else begin
                exp_src  = 32'(k % 2);
                exp_tag  = (exp_src == 0) ? 32'((k - 2) / 2) : 32'(16 + (k - 3) / 2);
                exp_data = (exp_src == 0) ? 32'hA000_0000 + exp_tag : 32'hB000_0000 + exp_tag;
                chk($sformatf("cont_valid_%0d", k), 32'(cdb_valid), 32'd1);
                chk($sformatf("cont_src_%0d", k), 32'(cdb_src), exp_src);
                chk($sformatf("cont_rob_%0d", k), 32'(cdb_rob_id), exp_tag);
                chk($sformatf("cont_data_%0d", k), cdb_data, exp_data);
                chk($sformatf("cont_cnt_%0d", k), contention_cnt, 32'(k - 1));
            end
        end
        chk("cont_phy_last", 32'(cdb_phy_dst), 32'd5);

        // Flush with both buffers full (ALU 5, mem 20 waiting)
        flush = 1'b1;
        #1;
        chk("flush_ready", 32'(req_ready), 32'd0);
        chk("flush_cycle_bcast", 32'(cdb_valid), 32'd1);
        tick_hs();
        flush = 1'b0; vld = 2'b00; apply();
        #1;
        chk("flush_valid_after", 32'(cdb_valid), 32'd0);
        chk("flush_cnt_kept", contention_cnt, 32'd9);
        tick_hs();
        chk("flush_no_stale", 32'(cdb_valid), 32'd0);
        alu_tag = 7; vld = 2'b01; apply();
        #1;
        chk("flush_ready_back", 32'(req_ready), 32'd3);
        tick_hs();
        vld = 2'b00; apply();
        chk("flush_new_wait", 32'(cdb_valid), 32'd0);
        tick_hs();
        chk("flush_new_valid", 32'(cdb_valid), 32'd1);
        chk("flush_new_rob", 32'(cdb_rob_id), 32'd7);
        chk("flush_new_src", 32'(cdb_src), 32'd0);
        tick_hs();
        chk("flush_idle", 32'(cdb_valid), 32'd0);
        chk("flush_cnt_idle", contention_cnt, 32'd9);

        // Fill both buffers with a broadcast in flight, then reset
        alu_tag = 8; mem_tag = 22; vld = 2'b11; apply();
        tick_hs();
        chk("refill_wait", 32'(cdb_valid), 32'd0);
        tick_hs();
        chk("refill_src_mem", 32'(cdb_src), 32'd1);
        chk("refill_rob_mem", 32'(cdb_rob_id), 32'd22);
        chk("refill_cnt", contention_cnt, 32'd10);
        tick_hs();
        chk("refill_src_alu", 32'(cdb_src), 32'd0);
        chk("refill_rob_alu", 32'(cdb_rob_id), 32'd8);
        chk("refill_cnt2", contention_cnt, 32'd11);
        rst_n = 1'b0;
        tick_hs();
        rst_n = 1'b1;
        #1;
        chk("mrst_valid", 32'(cdb_valid), 32'd0);
        chk("mrst_rob",   32'(cdb_rob_id), 32'd0);
        chk("mrst_phy",   32'(cdb_phy_dst), 32'd0);
        chk("mrst_data",  cdb_data, 32'd0);
        chk("mrst_src",   32'(cdb_src), 32'd0);
        chk("mrst_cnt",   contention_cnt, 32'd0);
        chk("mrst_ready", 32'(req_ready), 32'd3);
        chk("sat_rst",    s_contention_cnt, 32'hFFFF_FFFD);
        tick_hs();
        chk("mrst_wait", 32'(cdb_valid), 32'd0);
        tick_hs();
        chk("mrst_first_src", 32'(cdb_src), 32'd0);
        chk("mrst_first_rob", 32'(cdb_rob_id), 32'd10);
        chk("mrst_cnt_1", contention_cnt, 32'd1);
        chk("sat_fe", s_contention_cnt, 32'hFFFF_FFFE);
        tick_hs();
        chk("mrst_second_src", 32'(cdb_src), 32'd1);
        chk("mrst_second_rob", 32'(cdb_rob_id), 32'd24);
        chk("sat_ff", s_contention_cnt, 32'hFFFF_FFFF);
        for (int k = 0; k < 3; k++) begin
            tick_hs();
            chk($sformatf("sat_stick_%0d", k), s_contention_cnt, 32'hFFFF_FFFF);
        end
        chk("main_cnt_end", contention_cnt, 32'd5);

        vld = 2'b00; apply();
        tick_hs();
        tick_hs();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
